// File: rtl/sy_ppl_freelist.sv
// sy_ppl_freelist: physical-register free list with speculative/architectural heads and flush restore.
// Define SY_FREELIST_CHK_EN to add the in-list bitmap, RECOVER walk and sticky err_o.
module sy_ppl_freelist #(
    parameter int PHY_REG_NUM = 64,
    parameter int REG_WTH     = $clog2(PHY_REG_NUM),
    parameter int PTR_WTH     = REG_WTH + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               alloc_req_i,
    output logic               alloc_rdy_o,
    output logic [REG_WTH-1:0] alloc_phy_o,
    input  logic               commit_en_i,
    input  logic [REG_WTH-1:0] commit_old_phy_i,
    output logic [REG_WTH:0]   free_cnt_o,
    output logic               init_done_o,
    output logic               err_o
);
    localparam logic [1:0] INIT    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    logic [REG_WTH-1:0] mem_q [PHY_REG_NUM];
    logic [1:0]         state_q, state_d;
    logic [PTR_WTH-1:0] spec_head_q, spec_head_d, arch_head_q, arch_head_d, tail_q, tail_d;
    logic [REG_WTH-1:0] init_cnt_q, init_cnt_d, wr_data;
    logic               active, grant, commit, push, flush, wr_en, rec_done;

    assign active      = state_q != INIT;
    assign free_cnt_o  = tail_q - spec_head_q;
    assign alloc_rdy_o = state_q == RUN && !flush_i && free_cnt_o != '0;
    assign alloc_phy_o = active ? mem_q[spec_head_q[REG_WTH-1:0]] : '0;
    assign init_done_o = active;
    assign grant       = alloc_req_i && alloc_rdy_o;
    assign commit      = active && commit_en_i;
    assign push        = commit && commit_old_phy_i != '0;
    assign flush       = active && flush_i;
    assign wr_en       = !active || push;
    assign wr_data     = active ? commit_old_phy_i : init_cnt_q + 1'b1;

    always_comb begin
        arch_head_d = arch_head_q + PTR_WTH'(commit);
        tail_d      = tail_q + PTR_WTH'(wr_en);
        spec_head_d = flush ? arch_head_d : spec_head_q + PTR_WTH'(grant);
        init_cnt_d  = init_cnt_q + REG_WTH'(!active);
        state_d     = !active ? (init_cnt_q == REG_WTH'(PHY_REG_NUM - 2) ? RUN : INIT)
                    : (flush || (state_q == RECOVER && !rec_done)) ? RECOVER : RUN;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= '0;
            init_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            init_cnt_q  <= init_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[tail_q[REG_WTH-1:0]] <= wr_data;
    end

`ifdef SY_FREELIST_CHK_EN
    logic [PHY_REG_NUM-1:0] bmp_q, bmp_d;
    logic [PTR_WTH-1:0]     walk_q, walk_d, wend_q, wend_d;
    logic                   err_q, err_d, walking;

    assign walking  = state_q == RECOVER && walk_q != wend_q;
    assign rec_done = (wend_q - walk_q) <= PTR_WTH'(1);
    assign err_o    = err_q;

    // Flushed allocations [arch_head, old spec_head) are walked back into the bitmap.
    always_comb begin
        bmp_d = bmp_q;
        if (!active) bmp_d[wr_data] = 1'b1;
        if (walking) bmp_d[mem_q[walk_q[REG_WTH-1:0]]] = 1'b1;
        if (grant) bmp_d[alloc_phy_o] = 1'b0;
        if (push) bmp_d[commit_old_phy_i] = 1'b1;
        bmp_d[0] = 1'b0;
        walk_d = (state_q == RUN && flush_i) ? arch_head_d : walk_q + PTR_WTH'(walking);
        wend_d = (state_q == RUN && flush_i) ? spec_head_q : wend_q;
        err_d  = err_q || (push && (bmp_q[commit_old_phy_i] || free_cnt_o == PTR_WTH'(PHY_REG_NUM - 1)))
                       || (commit && arch_head_q == spec_head_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bmp_q  <= '0;
            walk_q <= '0;
            wend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            bmp_q  <= bmp_d;
            walk_q <= walk_d;
            wend_q <= wend_d;
            err_q  <= err_d;
        end
    end
`else
    assign rec_done = 1'b1;
    assign err_o    = 1'b0;
`endif
endmodule

// File: doc/sy_ppl_freelist.md
Name: sy_ppl_freelist

Overview:
- Physical-register free list and allocation controller for the rename stage.
- Hands out free physical destination registers to rename, which writes them into the RAT.
- Reclaims the previous mapping of each destination when the instruction retires from the ROB.
- Restores the speculative allocation pointer on pipeline flush, in step with the RAT's restore from the aRAT.
- Phys reg 0 is permanently bound to arch x0 and never enters the list.

Parameters:
PHY_REG_NUM, 64, number of physical registers; power of two, >= 64.
REG_WTH, $clog2(PHY_REG_NUM), physical index width.
PTR_WTH, REG_WTH+1, pointer width including the wrap bit.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
flush_i  in  1  pipeline flush (exception/mispredict).
alloc_req_i  in  1  rename wants one phys reg (rdst_en && arc_rdst != 0).
alloc_rdy_o  out  1  a free register is available this cycle.
alloc_phy_o  out  REG_WTH  register granted when req && rdy.
commit_en_i  in  1  ROB retires one instruction that allocated a register.
commit_old_phy_i  in  REG_WTH  previous mapping of the retired rdst, to be freed.
free_cnt_o  out  REG_WTH+1  free registers available to rename.
init_done_o  out  1  initialisation complete.
err_o  out  1  sticky error (only with SY_FREELIST_CHK_EN, else tied 0).

Behaviour:
- Storage: circular array of PHY_REG_NUM entries, each REG_WTH wide.
- Pointers, all PTR_WTH wide, wrap naturally:
  - spec_head: next entry to allocate.
  - arch_head: next entry to be consumed by a commit.
  - tail: next entry to write.
- free_cnt_o = tail - spec_head.
- Reset (async, rst_ni=0):
  - All pointers 0, state INIT, init counter 0.
  - Outputs: alloc_rdy_o=0, alloc_phy_o=0, free_cnt_o=0, init_done_o=0, err_o=0.
- FSM states: INIT, RUN, RECOVER.
- INIT:
  - Writes entry[i] = i+1 for i = 0..PHY_REG_NUM-2, one entry per cycle; tail increments each write.
  - After PHY_REG_NUM-1 cycles: go to RUN, init_done_o=1 from then on.
  - alloc_rdy_o=0. commit_en_i and flush_i are ignored.
- RUN:
  - alloc_rdy_o = (free_cnt_o != 0).
  - alloc_phy_o = entry[spec_head], combinational (0-cycle latency).
  - alloc_req_i && alloc_rdy_o: spec_head += 1.
  - commit_en_i: arch_head += 1.
  - commit_en_i with commit_old_phy_i != 0: entry[tail] = commit_old_phy_i, tail += 1.
  - commit_en_i with commit_old_phy_i == 0: no push.
  - Alloc and push in the same cycle: both take effect, free count unchanged. A register pushed this cycle is allocatable from the next cycle.
- flush_i in RUN:
  - spec_head <= arch_head as updated by any same-cycle commit; the commit is applied first.
  - Any same-cycle alloc is not granted (alloc_rdy_o forced 0 when flush_i=1).
  - Go to RECOVER.
- RECOVER:
  - Lasts 1 cycle, alloc_rdy_o=0, matching the RAT's one-cycle aRAT copy.
  - Commits still accepted.
  - flush_i again re-applies the restore and stays in RECOVER; otherwise return to RUN.
- Boundaries:
  - Empty (free_cnt=0): alloc_rdy_o=0; a same-cycle push makes it 1 next cycle.
  - Full: free_cnt never exceeds PHY_REG_NUM-1 by construction; a push at that count is a protocol error and the pointers still advance.
  - Reset mid-operation returns to INIT and re-initialises the full list.

Optional Feature:
SY_FREELIST_CHK_EN:
- Defined:
  - Adds a PHY_REG_NUM-bit "in-list" bitmap. INIT sets bits 1..PHY_REG_NUM-1 as it writes them; bit 0 is always 0.
  - Grant clears the bit. Push sets the bit.
  - On flush, bits of entries in [arch_head, spec_head) are set again via a walk during RECOVER. RECOVER then lasts (spec_head - arch_head) cycles, minimum 1.
  - err_o set sticky (cleared only by reset) on any of: a push of a register whose bit is already 1 (double free); a push when free_cnt=PHY_REG_NUM-1; a commit when arch_head == spec_head.
- Not defined: no bitmap, err_o tied 0, RECOVER always 1 cycle.

Test Plan:
- Reset, PHY_REG_NUM=64 -> init_done_o rises after 63 cycles; free_cnt_o=63, alloc_rdy_o=1, alloc_phy_o=1.
- 63 back-to-back allocs -> grants 1..63 in order; then free_cnt_o=0, alloc_rdy_o=0. Commit old_phy=5 -> next cycle alloc_rdy_o=1, alloc_phy_o=5.
- Same-cycle alloc and commit (old_phy=7) at free_cnt=10 -> free_cnt stays 10; 7 is granted after the 10 earlier entries.
- Alloc 4 (1..4), commit 1 (old=0, no push), flush -> free_cnt 59 -> 62; after 1 RECOVER cycle, alloc_phy_o=2.
- flush_i with alloc_req_i and commit_en_i in the same cycle -> no grant; arch_head counts the commit; spec_head equals the new arch_head.
- SY_FREELIST_CHK_EN: commit old_phy=3 while 3 is still in the list -> err_o=1 next cycle and stays 1 until reset.
